// File: rtl/pwm_duty_slew_limiter.sv
// Slew-rate limiter for the PWM duty path: walks duty_out toward target_duty
// in steps of at most step_size per prescaler tick, or tracks it directly in bypass.
module pwm_duty_slew_limiter #(
    parameter int RAMP_DIV = 3333,
    parameter int DIV_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] target_duty,
    input  logic [3:0] step_size,
    input  logic       ramp_en,
    output logic [7:0] duty_out,
    output logic       ramping,
    output logic       done_pulse
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);

    logic [1:0]       state_reg, state_next;
    logic [DIV_W-1:0] presc_reg, presc_next;
    logic [7:0]       duty_reg, duty_next;
    logic             done_reg, done_next;

    logic             tick;
    logic             tgt_above, tgt_below;
    logic [3:0]       eff_step;
    logic [8:0]       step_9, gap_up, gap_down;

    always_comb begin
        eff_step  = (step_size == 4'd0) ? 4'd1 : step_size;
        step_9    = {5'd0, eff_step};
        tgt_above = (target_duty > duty_reg);
        tgt_below = (target_duty < duty_reg);
        // 9-bit gaps so the no-overshoot compare can never wrap at 0x00/0xFF
        gap_up    = {1'b0, target_duty} - {1'b0, duty_reg};
        gap_down  = {1'b0, duty_reg} - {1'b0, target_duty};
        tick      = (state_reg != ST_IDLE) && (presc_reg == PRESC_LAST);

        state_next = state_reg;
        presc_next = presc_reg;
        duty_next  = duty_reg;
        done_next  = 1'b0;

        if (!ramp_en) begin
            duty_next  = target_duty;
            state_next = ST_IDLE;
            presc_next = '0;
        end else if (state_reg == ST_IDLE) begin
            presc_next = '0;
            if (tgt_above) begin
                state_next = ST_UP;
            end else if (tgt_below) begin
                state_next = ST_DOWN;
            end
        end else if (!tgt_above && !tgt_below) begin
            // Target moved onto the current duty between ticks: quietly stop.
            state_next = ST_IDLE;
            presc_next = '0;
        end else begin
            // Direction follows the live target; the prescaler keeps running.
            state_next = tgt_above ? ST_UP : ST_DOWN;
            presc_next = tick ? '0 : presc_reg + PRESC_ONE;
            if (tick) begin
                if (tgt_above) begin
                    if (gap_up <= step_9) begin
                        duty_next  = target_duty;
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        duty_next = duty_reg + {4'd0, eff_step};
                    end
                end else begin
                    if (gap_down <= step_9) begin
                        duty_next  = target_duty;
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        duty_next = duty_reg - {4'd0, eff_step};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            presc_reg <= '0;
            duty_reg  <= 8'h00;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            duty_reg  <= duty_next;
            done_reg  <= done_next;
        end
    end

    assign duty_out   = duty_reg;
    assign ramping    = (state_reg != ST_IDLE);
    assign done_pulse = done_reg;

endmodule

// File: tb/tb_pwm_duty_slew_limiter.sv
// Directed bench for pwm_duty_slew_limiter with RAMP_DIV=4; expected values
// are hand-derived from the ramp rules (first step 4 edges after leaving IDLE).
module tb_pwm_duty_slew_limiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] target_duty;
    logic [3:0] step_size;
    logic       ramp_en;
    logic [7:0] duty_out;
    logic       ramping;
    logic       done_pulse;

    int checks = 0;
    int errors = 0;

    pwm_duty_slew_limiter #(
        .RAMP_DIV(4),
        .DIV_W   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .target_duty(target_duty),
        .step_size  (step_size),
        .ramp_en    (ramp_en),
        .duty_out   (duty_out),
        .ramping    (ramping),
        .done_pulse (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Snapshot of all three outputs against expectations, one line per step.
    task automatic chk3(input string tag, input logic [7:0] d, input logic r, input logic p);
        chk({tag, ".duty"}, duty_out, d);
        chk({tag, ".ramping"}, {7'd0, ramping}, {7'd0, r});
        chk({tag, ".done"}, {7'd0, done_pulse}, {7'd0, p});
        $display("step %-14s duty=%02h ramping=%0b done=%0b", tag, duty_out, ramping, done_pulse);
    endtask

    task automatic bypass_to(input logic [7:0] v);
        ramp_en     = 1'b0;
        target_duty = v;
        edges(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b1;
        ramp_en     = 1'b0;
        target_duty = 8'h00;
        step_size   = 4'd4;
        #1 rst_n = 1'b0;
        #1;
        chk3("reset", 8'h00, 1'b0, 1'b0);
        edges(2);
        rst_n = 1'b1;
        edges(1);

        // Bypass: one cycle of latency, never ramping
        target_duty = 8'h80;
        chk3("byp_pre", 8'h00, 1'b0, 1'b0);
        edges(1);
        chk3("byp_post", 8'h80, 1'b0, 1'b0);

        // Up-ramp 0x00 -> 0x10, step 4
        bypass_to(8'h00);
        ramp_en = 1'b1; step_size = 4'd4; target_duty = 8'h10;
        edges(1);
        chk3("up_enter", 8'h00, 1'b1, 1'b0);
        edges(3);
        chk3("up_wait", 8'h00, 1'b1, 1'b0);
        edges(1);
        chk3("up_s1", 8'h04, 1'b1, 1'b0);
        edges(4);
        chk3("up_s2", 8'h08, 1'b1, 1'b0);
        edges(4);
        chk3("up_s3", 8'h0C, 1'b1, 1'b0);
        edges(4);
        chk3("up_s4", 8'h10, 1'b0, 1'b1);
        edges(1);
        chk3("up_after", 8'h10, 1'b0, 1'b0);

        // Down-ramp 0x0C -> 0x00, step 5
        bypass_to(8'h0C);
        ramp_en = 1'b1; step_size = 4'd5; target_duty = 8'h00;
        edges(5);
        chk3("dn_s1", 8'h07, 1'b1, 1'b0);
        edges(4);
        chk3("dn_s2", 8'h02, 1'b1, 1'b0);
        edges(4);
        chk3("dn_s3", 8'h00, 1'b0, 1'b1);

        // Reversal mid-ramp: up toward 0x20, retarget to 0x04 at 0x08
        step_size = 4'd4; target_duty = 8'h20;
        edges(5);
        chk3("rev_s1", 8'h04, 1'b1, 1'b0);
        edges(4);
        chk3("rev_s2", 8'h08, 1'b1, 1'b0);
        target_duty = 8'h04;
        edges(3);
        chk3("rev_wait", 8'h08, 1'b1, 1'b0);
        edges(1);
        chk3("rev_snap", 8'h04, 1'b0, 1'b1);

        // Target equal to duty between ticks: stop without a pulse
        target_duty = 8'h10;
        edges(5);
        chk3("eq_s1", 8'h08, 1'b1, 1'b0);
        target_duty = 8'h08;
        edges(1);
        chk3("eq_stop", 8'h08, 1'b0, 1'b0);

        // step_size 0 acts as 1
        bypass_to(8'hFE);
        ramp_en = 1'b1; step_size = 4'd0; target_duty = 8'hFF;
        edges(4);
        chk3("s0_wait", 8'hFE, 1'b1, 1'b0);
        edges(1);
        chk3("s0_step", 8'hFF, 1'b0, 1'b1);

        // Large step near the top: snaps without wrapping
        bypass_to(8'hF8);
        ramp_en = 1'b1; step_size = 4'd15; target_duty = 8'hFF;
        edges(5);
        chk3("s15_snap", 8'hFF, 1'b0, 1'b1);

        // ramp_en dropped mid-ramp: jump to target, no pulse
        bypass_to(8'h08);
        ramp_en = 1'b1; step_size = 4'd4; target_duty = 8'h40;
        edges(5);
        chk3("drop_s1", 8'h0C, 1'b1, 1'b0);
        ramp_en = 1'b0;
        edges(1);
        chk3("drop_byp", 8'h40, 1'b0, 1'b0);

        // Async reset mid-ramp, then restart from 0x00
        ramp_en = 1'b1; target_duty = 8'h80;
        edges(2);
        chk3("rst_pre", 8'h40, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk3("rst_async", 8'h00, 1'b0, 1'b0);
        target_duty = 8'h40;
        #1 rst_n = 1'b1;
        edges(4);
        chk3("rst_wait", 8'h00, 1'b1, 1'b0);
        edges(1);
        chk3("rst_s1", 8'h04, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
